dma_controller: RTL and testbench

Bus-master DMA engine that sits directly downstream of the interrupt handler. It consumes the handler's registered `cmd` and `BG`, and drives `BR` back to it. On command it moves a fixed-length block of words from an external device into data memory, using 4-word line writes. It raises `dma_end_int` when the block is done. The CPU's d-memory port and this block share the memory bus; `BR`/`BG` arbitrate ownership.

---
 rtl/dma_controller_pkg.sv | 31 +++
 rtl/dma_controller_addr_gen.sv | 49 ++++
 rtl/dma_controller.sv | 173 +++++++++++++++++
 tb/tb_dma_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_controller_pkg.sv
// dma_controller_pkg
// Shared constants for the block-move DMA engine: word size, default
// destination base address, default transfer length and the 3-bit FSM
// state encodings.
// Optional feature macro: DMA_BURST_RELEASE_EN adds the REL/REGRANT states
// used to hand the bus back to the CPU between bursts.
package dma_controller_pkg;

  localparam int              WORD_SIZE     = 16;
  localparam logic [15:0]     DMA_BASE_ADDR = 16'h01F4;
  localparam int              DMA_LENGTH    = 12;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t REQ     = 3'd1;
  localparam state_t XFER    = 3'd2;
  localparam state_t NEXT    = 3'd3;
  localparam state_t DONE    = 3'd4;
  localparam state_t WAITREL = 3'd5;
`ifdef DMA_BURST_RELEASE_EN
  localparam state_t REL     = 3'd6;
  localparam state_t REGRANT = 3'd7;
`endif

  // Counter width that stays legal (>= 1 bit) even for a single-burst block.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_controller_addr_gen.sv
// dma_addr_gen
// Burst counter k for the DMA engine. Produces the registered memory line
// address (BASE_ADDR + 4k, wrapping modulo 2^WORD_SIZE) and the registered
// device word offset (4k). k never advances past LENGTH/4-1.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - restart at burst 0
//   inc         - advance to the next burst
//   addr        - memory line address
//   idx         - device word offset of the current burst
//   last        - k is on the final burst
// Macro DMA_BURST_RELEASE_EN does not affect this module.
module dma_addr_gen #(
  parameter int                   WORD_SIZE = dma_controller_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR = dma_controller_pkg::DMA_BASE_ADDR,
  parameter int                   LENGTH    = dma_controller_pkg::DMA_LENGTH,
  parameter int                   IDXW      = $clog2(LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [WORD_SIZE-1:0] addr,
  output logic [IDXW-1:0]      idx,
  output logic                 last
);
  import dma_controller_pkg::*;

  localparam int          BURSTS = LENGTH / 4;
  localparam int          KW     = min1_clog2(BURSTS);
  localparam logic [KW-1:0] K_LAST = KW'(BURSTS - 1);

  logic [KW-1:0] k;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      k    <= '0;
      addr <= BASE_ADDR;
      idx  <= '0;
    end else if (inc && !last) begin
      k    <= k + 1'b1;
      addr <= addr + WORD_SIZE'(4);
      idx  <= idx + IDXW'(4);
    end
  end

  assign last = (k == K_LAST);

endmodule

// File: rtl/dma_controller.sv
// dma_controller
// Bus-master DMA engine: on cmd it requests the bus (BR), and once granted
// (BG) copies LENGTH words from the device into memory as LENGTH/4 line
// writes starting at BASE_ADDR, then pulses dma_end_int for one cycle and
// waits for the grant to be released.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   cmd          - start request (level)
//   BG / BR      - bus grant in / bus request out
//   dma_end_int  - one-cycle completion pulse
//   dev_idx      - device word offset of the burst being fetched
//   dev_data     - 4 device words at dev_idx (combinational from device)
//   m_addr       - memory line address
//   m_writeM     - memory write strobe (registered enable gated by BG)
//   m_data       - line write data, word 0 in the MSBs
//   m_doneWrite  - memory accepted the current line (one-cycle pulse)
// Macro DMA_BURST_RELEASE_EN: drop BR between bursts and wait for a fresh
// grant before each further burst. Undefined: BR held from REQ to DONE.
//
// state   | meaning
// IDLE    | bus not requested, waiting for cmd with BG low
// REQ     | BR raised, waiting for BG
// XFER    | line write in progress until m_doneWrite
// NEXT    | one-cycle gap between bursts
// DONE    | completion pulse, BR already low
// WAITREL | waiting for the handler to release BG
// REL     | (release build) BR low, waiting for BG to drop
// REGRANT | (release build) BR high again, waiting for BG
module dma_controller #(
  parameter int                   WORD_SIZE = dma_controller_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR = dma_controller_pkg::DMA_BASE_ADDR,
  parameter int                   LENGTH    = dma_controller_pkg::DMA_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd,
  input  logic                       BG,
  output logic                       BR,
  output logic                       dma_end_int,
  output logic [$clog2(LENGTH)-1:0]  dev_idx,
  input  logic [4*WORD_SIZE-1:0]     dev_data,
  output logic [WORD_SIZE-1:0]       m_addr,
  output logic                       m_writeM,
  output logic [4*WORD_SIZE-1:0]     m_data,
  input  logic                       m_doneWrite
);
  import dma_controller_pkg::*;

  state_t state, state_nxt;

  logic br_nxt, wr_nxt, end_nxt;
  logic load, inc, clr;
  logic wr_en;
  logic last;

  dma_addr_gen #(
    .WORD_SIZE (WORD_SIZE),
    .BASE_ADDR (BASE_ADDR),
    .LENGTH    (LENGTH),
    .IDXW      ($clog2(LENGTH))
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .addr  (m_addr),
    .idx   (dev_idx),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd && !BG) state_nxt = REQ;
      REQ:     if (BG) state_nxt = XFER;
      XFER:    if (m_doneWrite) state_nxt = last ? DONE : NEXT;
`ifdef DMA_BURST_RELEASE_EN
      NEXT:    state_nxt = REL;
      REL:     if (!BG) state_nxt = REGRANT;
      REGRANT: if (BG) state_nxt = XFER;
`else
      NEXT:    state_nxt = XFER;
`endif
      DONE:    state_nxt = WAITREL;
      WAITREL: if (!BG) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs. load captures dev_data on the
  // edge that enters XFER, when dev_idx already points at the burst.
  always_comb begin
    br_nxt  = 1'b0;
    wr_nxt  = 1'b0;
    end_nxt = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd && !BG) begin
          br_nxt = 1'b1;
          clr    = 1'b1;
        end
      end
      REQ: begin
        br_nxt = 1'b1;
        if (BG) begin
          wr_nxt = 1'b1;
          load   = 1'b1;
        end
      end
      XFER: begin
        br_nxt = 1'b1;
        wr_nxt = 1'b1;
        if (m_doneWrite) begin
          wr_nxt = 1'b0;
          if (last) begin
            br_nxt  = 1'b0;
            end_nxt = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
      end
`ifdef DMA_BURST_RELEASE_EN
      NEXT: begin
        br_nxt = 1'b0;
      end
      REL: begin
        if (!BG) br_nxt = 1'b1;
      end
      REGRANT: begin
        br_nxt = 1'b1;
        if (BG) begin
          wr_nxt = 1'b1;
          load   = 1'b1;
        end
      end
`else
      NEXT: begin
        br_nxt = 1'b1;
        wr_nxt = 1'b1;
        load   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      BR          <= 1'b0;
      wr_en       <= 1'b0;
      dma_end_int <= 1'b0;
      m_data      <= '0;
    end else begin
      BR          <= br_nxt;
      wr_en       <= wr_nxt;
      dma_end_int <= end_nxt;
      if (load) m_data <= dev_data;
    end
  end

  // A dropped grant suspends the write without losing the pending line.
  assign m_writeM = wr_en & BG;

endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller
// Self-checking bench for dma_controller: a cycle table for one transfer
// driven by hand, then sequences using a small handler/memory model
// (grant follows request, write accepted 2 cycles into each write).
module tb_dma_controller;

  localparam int LENGTH = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd = 1'b0;
  logic        BG = 1'b0;
  logic        BR;
  logic        dma_end_int;
  logic [3:0]  dev_idx;
  logic [63:0] dev_data;
  logic [15:0] m_addr;
  logic        m_writeM;
  logic [63:0] m_data;
  logic        m_doneWrite = 1'b0;

  dma_controller dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd),
    .BG          (BG),
    .BR          (BR),
    .dma_end_int (dma_end_int),
    .dev_idx     (dev_idx),
    .dev_data    (dev_data),
    .m_addr      (m_addr),
    .m_writeM    (m_writeM),
    .m_data      (m_data),
    .m_doneWrite (m_doneWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dw(input int i);
    return 16'hC000 + 16'(i);
  endfunction

  function automatic logic [63:0] exp_line(input int n);
    return {dw(4*n), dw(4*n+1), dw(4*n+2), dw(4*n+3)};
  endfunction

  assign dev_data = {dw(int'(dev_idx)), dw(int'(dev_idx)+1),
                     dw(int'(dev_idx)+2), dw(int'(dev_idx)+3)};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model state
  int   wcnt, nwr, nend, brlow;
  logic ended, mid;

  task automatic clr_model();
    wcnt = 0; nwr = 0; nend = 0; brlow = 0; ended = 0; mid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd = 1'b0; BG = 1'b0; m_doneWrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clr_model();
  endtask

  // One cycle of handler + memory model; called and returns at a negedge.
  task automatic cyc(input logic c, input logic force_low);
    logic br_s, wr_s;
    br_s = BR;
    wr_s = m_writeM;
    cmd = c;
    if (force_low)          BG = 1'b0;
    else if (br_s)          BG = 1'b1;
    else if (!(ended && c)) BG = 1'b0;
    m_doneWrite = 1'b0;
    if (wr_s) begin
      mid = 1'b1;
      wcnt++;
      if (wcnt == 2) begin
        m_doneWrite = 1'b1;
        wcnt = 0;
        chk("wr_addr", 64'(m_addr), 64'(16'h01F4 + 16'(4*nwr)));
        chk("wr_data", m_data, exp_line(nwr));
        nwr++;
      end
    end else begin
      wcnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    if (dma_end_int) begin
      nend++;
      ended = 1'b1;
      mid = 1'b0;
    end else if (mid && !BR) begin
      brlow++;
    end
    if (!c) ended = 1'b0;
  endtask

  task automatic run_until_end(input int limit, input logic c);
    int n0;
    n0 = nend;
    for (int i = 0; i < limit && nend == n0; i++) cyc(c, 1'b0);
    chk("end_seen", 64'(nend), 64'(n0 + 1));
  endtask

  typedef struct {
    logic        cmd, bg, done;
    logic        br, wr, en;
    logic [15:0] addr;
    logic [3:0]  idx;
    logic [63:0] data;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic g, input logic d,
                              input logic br, input logic wr, input logic en,
                              input logic [15:0] a, input logic [3:0] x,
                              input logic [63:0] dt);
    vec_t v;
    v.cmd = c; v.bg = g; v.done = d; v.br = br; v.wr = wr; v.en = en;
    v.addr = a; v.idx = x; v.data = dt;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d0, d1, d2;
    d0 = exp_line(0); d1 = exp_line(1); d2 = exp_line(2);

    //              cmd bg dn   br wr en  addr      idx data
    vecs[0]  = mk(0, 0, 0,  0, 0, 0, 16'h01F4, 0, 64'h0);
    vecs[1]  = mk(1, 0, 0,  1, 0, 0, 16'h01F4, 0, 64'h0);
    vecs[2]  = mk(0, 0, 0,  1, 0, 0, 16'h01F4, 0, 64'h0);
    vecs[3]  = mk(0, 1, 0,  1, 1, 0, 16'h01F4, 0, d0);
    vecs[4]  = mk(0, 1, 0,  1, 1, 0, 16'h01F4, 0, d0);
    vecs[5]  = mk(0, 1, 1,  1, 0, 0, 16'h01F8, 4, d0);
    vecs[6]  = mk(0, 1, 0,  1, 1, 0, 16'h01F8, 4, d1);
    vecs[7]  = mk(0, 1, 1,  1, 0, 0, 16'h01FC, 8, d1);
    vecs[8]  = mk(0, 1, 0,  1, 1, 0, 16'h01FC, 8, d2);
    vecs[9]  = mk(0, 0, 0,  1, 0, 0, 16'h01FC, 8, d2);
    vecs[10] = mk(0, 1, 0,  1, 1, 0, 16'h01FC, 8, d2);
    vecs[11] = mk(0, 1, 1,  0, 0, 1, 16'h01FC, 8, d2);
    vecs[12] = mk(0, 1, 0,  0, 0, 0, 16'h01FC, 8, d2);
    vecs[13] = mk(1, 1, 0,  0, 0, 0, 16'h01FC, 8, d2);
    vecs[14] = mk(0, 0, 0,  0, 0, 0, 16'h01FC, 8, d2);
    vecs[15] = mk(1, 1, 0,  0, 0, 0, 16'h01FC, 8, d2);
    vecs[16] = mk(0, 1, 1,  0, 0, 0, 16'h01FC, 8, d2);
    vecs[17] = mk(1, 0, 0,  1, 0, 0, 16'h01F4, 0, d2);
    vecs[18] = mk(0, 0, 1,  1, 0, 0, 16'h01F4, 0, d2);

    // reset values
    do_reset();
    chk("rst_BR", 64'(BR), 64'(0));
    chk("rst_writeM", 64'(m_writeM), 64'(0));
    chk("rst_end", 64'(dma_end_int), 64'(0));
    chk("rst_addr", 64'(m_addr), 64'(16'h01F4));
    chk("rst_data", m_data, 64'h0);
    chk("rst_idx", 64'(dev_idx), 64'(0));

`ifndef DMA_BURST_RELEASE_EN
    // cycle-exact table for one transfer plus ignored-input corners
    for (int i = 0; i < 19; i++) begin
      cmd = vecs[i].cmd; BG = vecs[i].bg; m_doneWrite = vecs[i].done;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_BR", i), 64'(BR), 64'(vecs[i].br));
      chk($sformatf("tbl%0d_writeM", i), 64'(m_writeM), 64'(vecs[i].wr));
      chk($sformatf("tbl%0d_end", i), 64'(dma_end_int), 64'(vecs[i].en));
      chk($sformatf("tbl%0d_addr", i), 64'(m_addr), 64'(vecs[i].addr));
      chk($sformatf("tbl%0d_idx", i), 64'(dev_idx), 64'(vecs[i].idx));
      chk($sformatf("tbl%0d_data", i), m_data, vecs[i].data);
    end
`endif

    // basic transfer with cmd at cycle 2
    do_reset();
    cyc(0, 0); cyc(0, 0); cyc(1, 0);
    run_until_end(80, 0);
    chk("basic_writes", 64'(nwr), 64'(LENGTH / 4));
    chk("basic_BR_after_end", 64'(BR), 64'(0));
`ifdef DMA_BURST_RELEASE_EN
    chk("basic_BR_released", 64'(brlow > 0), 64'(1));
`else
    chk("basic_BR_held", 64'(brlow), 64'(0));
`endif
    repeat (4) cyc(0, 0);
    chk("basic_end_count", 64'(nend), 64'(1));
    chk("basic_idle_BR", 64'(BR), 64'(0));

    // cmd held high for 40 cycles: one transfer only
    do_reset();
    repeat (40) cyc(1, 0);
    repeat (8) cyc(0, 0);
    chk("hold_end_count", 64'(nend), 64'(1));
    chk("hold_writes", 64'(nwr), 64'(LENGTH / 4));
    chk("hold_BR", 64'(BR), 64'(0));

    // grant dropped for 3 cycles during the second burst
    do_reset();
    cyc(1, 0);
    for (int i = 0; i < 40 && !(m_writeM && nwr == 1); i++) cyc(0, 0);
    chk("gap_reach", 64'(m_writeM && nwr == 1), 64'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1);
      chk("gap_writeM", 64'(m_writeM), 64'(0));
      chk("gap_addr", 64'(m_addr), 64'(16'h01F8));
      chk("gap_BR", 64'(BR), 64'(1));
    end
    run_until_end(80, 0);
    chk("gap_writes", 64'(nwr), 64'(LENGTH / 4));

    // reset during the second burst, then a fresh transfer
    do_reset();
    cyc(1, 0);
    for (int i = 0; i < 40 && !(m_writeM && nwr == 1); i++) cyc(0, 0);
    chk("rstmid_reach", 64'(m_writeM && nwr == 1), 64'(1));
    m_doneWrite = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_BR", 64'(BR), 64'(0));
    chk("rstmid_writeM", 64'(m_writeM), 64'(0));
    chk("rstmid_end", 64'(dma_end_int), 64'(0));
    clr_model();
    repeat (10) cyc(0, 0);
    chk("rstmid_no_end", 64'(nend), 64'(0));
    chk("rstmid_no_write", 64'(nwr), 64'(0));
    cyc(1, 0);
    chk("rstmid_restart_addr", 64'(m_addr), 64'(16'h01F4));
    run_until_end(80, 0);
    chk("rstmid_writes", 64'(nwr), 64'(LENGTH / 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
